// File: rtl/conway_pkg.sv
// Shared types and sizing helpers for the grid load controller and its divider.
package conway_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOADING,
    COMMIT,
    READY,
    RUN
  } state_t;

  function automatic int chunk_count(input int data_size, input int in_width);
    return data_size / in_width;
  endfunction

  // A counter spanning 0..n-1 needs at least one bit even when n is 1.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/grid_load_controller_step_divider.sv
// Modulo-STEP_DIV cycle counter; tick is high while the count sits on its last value.
module step_divider
  import conway_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = cnt_width(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/grid_load_controller.sv
// Assembles the initial grid from a chunk stream, commits it to memory, then paces
// generation writes with start/stop/reload control.
module grid_load_controller
  import conway_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int IN_WIDTH  = 8,
  parameter int STEP_DIV  = 4,
  parameter int GEN_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [IN_WIDTH-1:0]  LOAD_DATA,
  input  logic                 LOAD_VALID,
  output logic                 LOAD_READY,
  input  logic                 START,
  input  logic                 STOP,
  input  logic                 RELOAD,
  output logic [DATA_SIZE-1:0] INITIAL_OUT,
  output logic                 WRITE_ENABLE,
  output logic                 LOAD_RUN,
  output logic                 LOADED,
  output logic [GEN_W-1:0]     GEN_COUNT
);

  localparam int NCHUNK = chunk_count(DATA_SIZE, IN_WIDTH);
  localparam int CW = cnt_width(NCHUNK);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  if (DATA_SIZE % IN_WIDTH != 0) begin : g_bad_width
    $error("DATA_SIZE must be a multiple of IN_WIDTH");
  end
  if (STEP_DIV < 1) begin : g_bad_div
    $error("STEP_DIV must be at least 1");
  end

  state_t state, state_next;
  logic [DATA_SIZE-1:0] sr, sr_shifted;
  logic [CW-1:0] chunk_cnt;
  logic [GEN_W-1:0] gen_count;
  logic accept, reload_now, last_accept, tick;

  assign accept      = LOAD_VALID && LOAD_READY;
  assign last_accept = accept && (chunk_cnt == LAST_CHUNK);
  // COMMIT always completes its single write; a held RELOAD lands one cycle later.
  assign reload_now  = RELOAD && (state != COMMIT);

  if (NCHUNK == 1) begin : g_single
    assign sr_shifted = LOAD_DATA;
  end else begin : g_multi
    assign sr_shifted = {sr[DATA_SIZE-IN_WIDTH-1:0], LOAD_DATA};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (reload_now)       state_next = IDLE;
        else if (last_accept) state_next = COMMIT;
        else if (accept)      state_next = LOADING;
      end
      LOADING: begin
        if (reload_now)       state_next = IDLE;
        else if (last_accept) state_next = COMMIT;
      end
      COMMIT: state_next = READY;
      READY: begin
        if (reload_now)  state_next = IDLE;
        else if (STOP)   state_next = READY;
        else if (START)  state_next = RUN;
      end
      RUN: begin
        if (reload_now)  state_next = IDLE;
        else if (STOP)   state_next = READY;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    LOAD_READY   = 1'b0;
    WRITE_ENABLE = 1'b0;
    LOAD_RUN     = 1'b0;
    LOADED       = 1'b0;
    case (state)
      IDLE, LOADING: LOAD_READY = 1'b1;
      COMMIT:        WRITE_ENABLE = 1'b1;
      READY:         LOADED = 1'b1;
      RUN: begin
        LOADED       = 1'b1;
        LOAD_RUN     = 1'b1;
        WRITE_ENABLE = tick;
      end
      default: ;
    endcase
  end

  // Shift register keeps its contents across RELOAD; only the chunk count restarts.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sr        <= '0;
      chunk_cnt <= '0;
    end else if (reload_now) begin
      chunk_cnt <= '0;
    end else if (accept) begin
      sr        <= sr_shifted;
      chunk_cnt <= last_accept ? '0 : chunk_cnt + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      gen_count <= '0;
    end else if (reload_now || state == COMMIT) begin
      gen_count <= '0;
    end else if (state == RUN && tick) begin
      gen_count <= gen_count + GEN_W'(1);
    end
  end

  // Divider is held at zero whenever the next cycle is not a RUN cycle.
  step_divider #(
    .STEP_DIV(STEP_DIV)
  ) u_step_divider (
    .clk   (CLK),
    .rst   (RESET),
    .clear (state_next != RUN),
    .enable(state == RUN),
    .tick  (tick)
  );

  assign INITIAL_OUT = sr;
  assign GEN_COUNT   = gen_count;

endmodule

// File: tb/tb_grid_load_controller.sv
// Directed bench: a STEP_DIV=3 controller for load/run/reload/reset and a
// STEP_DIV=1, GEN_W=2 controller for per-cycle pulses and counter wrap.
module tb_grid_load_controller;

  logic clk = 1'b0;
  logic rst;

  logic [3:0]  load_data;
  logic        load_valid, start, stop, reload;
  logic        load_ready, write_enable, load_run, loaded;
  logic [15:0] initial_out;
  logic [15:0] gen_count;

  logic [3:0]  d1_load_data;
  logic        d1_load_valid, d1_start, d1_stop, d1_reload;
  logic        d1_load_ready, d1_write_enable, d1_load_run, d1_loaded;
  logic [15:0] d1_initial_out;
  logic [1:0]  d1_gen_count;

  int total = 0;
  int bad = 0;

  grid_load_controller #(
    .DATA_SIZE(16), .IN_WIDTH(4), .STEP_DIV(3), .GEN_W(16)
  ) u_dut (
    .CLK(clk), .RESET(rst),
    .LOAD_DATA(load_data), .LOAD_VALID(load_valid), .LOAD_READY(load_ready),
    .START(start), .STOP(stop), .RELOAD(reload),
    .INITIAL_OUT(initial_out), .WRITE_ENABLE(write_enable), .LOAD_RUN(load_run),
    .LOADED(loaded), .GEN_COUNT(gen_count)
  );

  grid_load_controller #(
    .DATA_SIZE(16), .IN_WIDTH(4), .STEP_DIV(1), .GEN_W(2)
  ) u_dut_fast (
    .CLK(clk), .RESET(rst),
    .LOAD_DATA(d1_load_data), .LOAD_VALID(d1_load_valid), .LOAD_READY(d1_load_ready),
    .START(d1_start), .STOP(d1_stop), .RELOAD(d1_reload),
    .INITIAL_OUT(d1_initial_out), .WRITE_ENABLE(d1_write_enable), .LOAD_RUN(d1_load_run),
    .LOADED(d1_loaded), .GEN_COUNT(d1_gen_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    load_data = '0; load_valid = 0; start = 0; stop = 0; reload = 0;
    d1_load_data = '0; d1_load_valid = 0; d1_start = 0; d1_stop = 0; d1_reload = 0;

    #12;
    check("rst_ready", load_ready, 1);
    check("rst_out", initial_out, 0);
    check("rst_we", write_enable, 0);
    check("rst_run", load_run, 0);
    check("rst_loaded", loaded, 0);
    check("rst_gen", gen_count, 0);
    rst = 1'b0;

    // Back-to-back load of A,B,C,D
    load_valid = 1;
    load_data = 4'hA; tick();
    load_data = 4'hB; tick();
    load_data = 4'hC; tick();
    load_data = 4'hD; tick();
    load_valid = 0;
    check("b2b_out", initial_out, 16'hABCD);
    check("b2b_we", write_enable, 1);
    check("b2b_loadrun", load_run, 0);
    check("b2b_commit_ready", load_ready, 0);
    tick();
    check("b2b_we_off", write_enable, 0);
    check("b2b_loaded", loaded, 1);
    check("b2b_ready_low", load_ready, 0);

    // Ignored chunk while READY, then reload and a toggling-valid load
    load_valid = 1; load_data = 4'h5; tick();
    load_valid = 0;
    check("ready_ignore", initial_out, 16'hABCD);
    reload = 1; tick(); reload = 0;
    check("reload_idle_ready", load_ready, 1);
    check("reload_idle_loaded", loaded, 0);
    load_valid = 1; load_data = 4'hA; tick();
    load_valid = 0; load_data = 4'hF; tick();
    load_valid = 1; load_data = 4'hB; tick();
    check("tog_partial", initial_out, 16'hCDAB);
    load_valid = 0; load_data = 4'hF; tick();
    check("tog_hold", initial_out, 16'hCDAB);
    load_valid = 1; load_data = 4'hC; tick();
    load_valid = 0; load_data = 4'hF; tick();
    check("tog_not_yet", write_enable, 0);
    load_valid = 1; load_data = 4'hD; tick();
    load_valid = 0;
    check("tog_out", initial_out, 16'hABCD);
    check("tog_we", write_enable, 1);
    tick();
    check("tog_loaded", loaded, 1);

    // START held 10 cycles: pulses on cycles 3, 6, 9
    start = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("run_we_c%0d", k), write_enable, ((k % 3) == 0) ? 1 : 0);
      check($sformatf("run_gen_c%0d", k), gen_count, (k - 1) / 3);
      check($sformatf("run_lr_c%0d", k), load_run, 1);
    end
    start = 0;

    // STOP coinciding with a run pulse
    tick();
    tick();
    check("stop_pulse_we", write_enable, 1);
    check("stop_pulse_gen", gen_count, 3);
    stop = 1; tick(); stop = 0;
    check("stop_gen", gen_count, 4);
    check("stop_loaded", loaded, 1);
    check("stop_lr", load_run, 0);
    check("stop_we", write_enable, 0);
    start = 1; tick(); start = 0;
    check("restart_c1_we", write_enable, 0);
    check("restart_c1_lr", load_run, 1);
    tick();
    check("restart_c2_we", write_enable, 0);
    tick();
    check("restart_c3_we", write_enable, 1);
    tick();
    check("restart_gen", gen_count, 5);

    // RELOAD mid-run, then RELOAD after two chunks, then a fresh load
    reload = 1; tick(); reload = 0;
    check("rl_gen", gen_count, 0);
    check("rl_ready", load_ready, 1);
    check("rl_lr", load_run, 0);
    load_valid = 1;
    load_data = 4'h1; tick();
    load_data = 4'h2; tick();
    load_valid = 0;
    check("rl_partial", initial_out, 16'hCD12);
    reload = 1; tick(); reload = 0;
    check("rl2_keep_sr", initial_out, 16'hCD12);
    check("rl2_ready", load_ready, 1);
    load_valid = 1;
    load_data = 4'h5; tick();
    load_data = 4'h6; tick();
    load_data = 4'h7; tick();
    check("fresh_no_commit", write_enable, 0);
    check("fresh_still_ready", load_ready, 1);
    load_data = 4'h8; tick();
    load_valid = 0;
    check("fresh_we", write_enable, 1);
    check("fresh_out", initial_out, 16'h5678);
    tick();
    check("fresh_loaded", loaded, 1);

    // Asynchronous reset in the middle of a run pulse
    start = 1; tick(); tick(); tick();
    check("prerst_we", write_enable, 1);
    rst = 1; #1;
    check("arst_we", write_enable, 0);
    check("arst_lr", load_run, 0);
    check("arst_loaded", loaded, 0);
    check("arst_ready", load_ready, 1);
    check("arst_out", initial_out, 0);
    check("arst_gen", gen_count, 0);
    start = 0;
    #2 rst = 0;

    // STEP_DIV=1, GEN_W=2: pulse every cycle and 2-bit wrap
    d1_load_valid = 1;
    d1_load_data = 4'h1; tick();
    d1_load_data = 4'h2; tick();
    d1_load_data = 4'h3; tick();
    d1_load_data = 4'h4; tick();
    d1_load_valid = 0;
    check("fast_out", d1_initial_out, 16'h1234);
    check("fast_commit_lr", d1_load_run, 0);
    tick();
    check("fast_loaded", d1_loaded, 1);
    d1_start = 1; tick();
    check("fast_c1_we", d1_write_enable, 1);
    check("fast_c1_gen", d1_gen_count, 0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("fast_we_%0d", k), d1_write_enable, 1);
      check($sformatf("fast_gen_%0d", k), d1_gen_count, k % 4);
    end
    d1_start = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
